// File: rtl/async_bus_capture.sv
// async_bus_capture
// Sequences capture of an asynchronous strobe-qualified parallel bus.
// Strobe and data are each reclocked through STAGES flops. A rising edge on
// the synchronized strobe starts a SETTLE_CYCLES wait. After the wait the
// synchronized word is latched and offered on a valid/ready handshake.
//
// Optional feature, enabled with `define CAPTURE_STROBE_FILTER_EN:
//   A 3-sample glitch filter follows the strobe synchronizer. Strobe pulses
//   shorter than 3 cycles are rejected, and capture latency grows by 2 cycles.
//
// Ports:
//   clk, rst_n    system clock and asynchronous active-low reset
//   strobe_async  asynchronous strobe; a rising edge marks new data
//   data_async    asynchronous data, held stable by the source around the strobe
//   data_out      captured word; keeps its value after acceptance
//   valid, ready  handshake; the word is consumed when valid && ready
//   busy          high while a capture is settling or being held
//   overrun       sticky; set when a strobe edge was dropped
//   overrun_clr   single-cycle pulse that clears overrun (a same-cycle set wins)
module async_bus_capture #(
  parameter int WIDTH         = 8,
  parameter int STAGES        = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe_async,
  input  logic [WIDTH-1:0] data_async,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [STAGES-1:0]             strobe_pipe;
  logic [STAGES-1:0][WIDTH-1:0]  data_pipe;
  logic                          strobe_sync;
  logic [WIDTH-1:0]              data_sync;
  logic                          strobe_filt;
  logic                          strobe_prev;
  logic                          strobe_edge;
  logic                          accept;
  logic                          drop;

  // Reclocking chains; index 0 is the first flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_pipe <= '0;
      data_pipe   <= '0;
    end else begin
      strobe_pipe <= {strobe_pipe[STAGES-2:0], strobe_async};
      data_pipe   <= {data_pipe[STAGES-2:0], data_async};
    end
  end

  assign strobe_sync = strobe_pipe[STAGES-1];
  assign data_sync   = data_pipe[STAGES-1];

`ifdef CAPTURE_STROBE_FILTER_EN
  // The current synchronized sample plus two older ones form the 3-sample
  // window. strobe_prev is the filter output of the previous cycle, so it
  // doubles as the hold value when the window is mixed.
  logic [1:0] strobe_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe_hist <= '0;
    else        strobe_hist <= {strobe_hist[0], strobe_sync};
  end

  always_comb begin
    strobe_filt = strobe_prev;
    if (strobe_sync && (&strobe_hist))        strobe_filt = 1'b1;
    else if (!strobe_sync && !(|strobe_hist)) strobe_filt = 1'b0;
  end
`else
  assign strobe_filt = strobe_sync;
`endif

  assign strobe_edge = strobe_filt & ~strobe_prev;
  assign accept      = valid & ready;
  // An edge is lost when the block cannot start a new capture this cycle.
  assign drop        = strobe_edge &
                       ((state == SETTLE) || ((state == HOLD) && !accept));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      strobe_prev <= 1'b0;
    end else begin
      strobe_prev <= strobe_filt;

      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;

      // busy is updated alongside every state change so it always equals
      // (state != IDLE).
      case (state)
        IDLE: begin
          if (strobe_edge) begin
            state <= SETTLE;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            data_out <= data_sync;
            valid    <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            valid <= 1'b0;
            // Back-to-back: a new edge in the accept cycle restarts settling.
            if (strobe_edge) begin
              state <= SETTLE;
              cnt   <= CNT_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
